eea_ctrl: RTL and testbench

Control sequencer for the shift-add `a*x + b*y` datapath.
- Accepts a start request carrying the two 8-bit multipliers `a` and `b`.
- Emits the load, shift, select, count and accumulate strobes that make the datapath form `a*x + b*y` in its accumulator, using eight add/shift steps per product.
- Signals completion with a one-cycle `done` pulse and reports its phase on `status`.
- Sits directly in front of the datapath. It is the driving end of that datapath's strobe interface.

---
 rtl/eea_ctrl.sv | 99 +++++++++
 tb/tb_eea_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/eea_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : eea_ctrl
// Brief   : Strobe sequencer driving a shift-add datapath to form a*x + b*y.
// Rev     : 1.0  initial release
// ============================================================================
module eea_ctrl #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             plx,
    output logic             ply,
    output logic             clrrez,
    output logic             shiftx,
    output logic             shifty,
    output logic             sel,
    output logic             incxy,
    output logic             plrez,
    output logic [4:0]       status
);

    localparam int              c_CW   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NBITS - 1);

    // One-hot state codes double as the status word.
    localparam logic [4:0] c_IDLE = 5'b00001;
    localparam logic [4:0] c_LOAD = 5'b00010;
    localparam logic [4:0] c_MULX = 5'b00100;
    localparam logic [4:0] c_MULY = 5'b01000;
    localparam logic [4:0] c_DONE = 5'b10000;

    logic [4:0]       r_state;
    logic [NBITS-1:0] r_ma;
    logic [NBITS-1:0] r_mb;
    logic [c_CW-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_ma    <= '0;
            r_mb    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_ma    <= a;
                        r_mb    <= b;
                        r_cnt   <= '0;
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: r_state <= c_MULX;
                c_MULX: begin
                    r_ma <= r_ma >> 1;
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_MULY;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_MULY: begin
                    r_mb <= r_mb >> 1;
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Strobes depend only on registered state, so no input reaches an output.
    assign ready  = (r_state == c_IDLE);
    assign done   = (r_state == c_DONE);
    assign plx    = (r_state == c_LOAD);
    assign ply    = (r_state == c_LOAD);
    assign clrrez = (r_state == c_LOAD);
    assign shiftx = (r_state == c_MULX);
    assign shifty = (r_state == c_MULY);
    assign sel    = (r_state == c_MULY);
    assign incxy  = (r_state == c_MULX) || (r_state == c_MULY);
    assign plrez  = ((r_state == c_MULX) && r_ma[0]) ||
                    ((r_state == c_MULY) && r_mb[0]);
    assign status = r_state;

endmodule
`default_nettype wire

// File: tb/tb_eea_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_eea_ctrl
// Brief   : Randomised scoreboard bench for eea_ctrl with a datapath model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_eea_ctrl;

    localparam int N   = 8;
    localparam int LAT = 2 * N + 2;

    typedef struct {
        logic [15:0] exp_acc;
        int          cyc;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b1;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;

    logic ready, done, plx, ply, clrrez, shiftx, shifty, sel, incxy, plrez;
    logic [4:0] status;

    eea_ctrl #(.NBITS(N)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .plx(plx), .ply(ply), .clrrez(clrrez),
        .shiftx(shiftx), .shifty(shifty), .sel(sel), .incxy(incxy),
        .plrez(plrez), .status(status)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    txn_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference schedule: rem counts cycles left in the operation (0 = idle).
    int          rem = 0;
    int          cyc = 0;
    logic        started = 1'b0;
    logic [N-1:0] cur_a = '0, cur_b = '0;

    always @(posedge clk) begin
        txn_t t;
        cyc = cyc + 1;
        if (reset) begin
            rem = 0;
            started = 1'b1;
            sb_q.delete();
        end else if (rem == 0 && start) begin
            cur_a = a;
            cur_b = b;
            rem = LAT;
            t.exp_acc = 16'((int'(a) * int'(x) + int'(b) * int'(y)) & 32'hFFFF);
            t.cyc = cyc;
            sb_q.push_back(t);
        end else if (rem > 0) begin
            rem = rem - 1;
        end
    end

    function automatic logic [14:0] expect_out(input int c, input logic [N-1:0] ea, input logic [N-1:0] eb);
        logic rdy, dn, px, py, clr, sx, sy, sl, inc, pr;
        logic [4:0] st;
        {rdy, dn, px, py, clr, sx, sy, sl, inc, pr} = '0;
        st = 5'b00001;
        if (c == 0) begin
            rdy = 1'b1;
        end else if (c == 1) begin
            px = 1'b1; py = 1'b1; clr = 1'b1; st = 5'b00010;
        end else if (c <= N + 1) begin
            sx = 1'b1; inc = 1'b1; pr = ea[c-2]; st = 5'b00100;
        end else if (c <= 2 * N + 1) begin
            sy = 1'b1; sl = 1'b1; inc = 1'b1; pr = eb[c-N-2]; st = 5'b01000;
        end else begin
            dn = 1'b1; st = 5'b10000;
        end
        return {rdy, dn, px, py, clr, sx, sy, sl, inc, pr, st};
    endfunction

    // Behavioural datapath, fed by strobes latched at the previous negedge.
    logic [15:0] xs = '0, ys = '0, acc = '0;
    logic m_plx = 0, m_ply = 0, m_clr = 0, m_sx = 0, m_sy = 0, m_sel = 0, m_plrez = 0;
    int   ninc = 0;

    always @(posedge clk) begin
        if (m_clr) acc <= '0;
        else if (m_plrez) acc <= acc + (m_sel ? ys : xs);
        if (m_plx) xs <= 16'(x);
        else if (m_sx) xs <= xs << 1;
        if (m_ply) ys <= 16'(y);
        else if (m_sy) ys <= ys << 1;
    end

    // Monitor: per-cycle strobe check, and scoreboard pop on done.
    always @(negedge clk) begin
        txn_t t;
        {m_plx, m_ply, m_clr, m_sx, m_sy, m_sel, m_plrez} = {plx, ply, clrrez, shiftx, shifty, sel, plrez};
        if (plx) ninc = 0;
        if (incxy) ninc = ninc + 1;
        if (started) begin
            check("strobes", {17'd0, ready, done, plx, ply, clrrez, shiftx, shifty, sel, incxy, plrez, status},
                  {17'd0, expect_out((rem == 0) ? 0 : (LAT + 1 - rem), cur_a, cur_b)});
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("done_without_txn", 32'd1, 32'd0);
                end else begin
                    t = sb_q.pop_front();
                    check("accumulator", {16'd0, acc}, {16'd0, t.exp_acc});
                    check("done_latency", cyc - t.cyc + 1, LAT);
                    check("incxy_count", ninc, 2 * N);
                end
            end
        end
    end

    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic [N-1:0] ix, input logic [N-1:0] iy);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; x = ix; y = iy;
        @(negedge clk);
        start = 1'b0; a = N'($urandom); b = N'($urandom);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        // Reset held two cycles with start asserted: must stay idle.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        run_op(8'd3, 8'd2, 8'd5, 8'd7);
        run_op(8'd0, 8'd0, N'($urandom), N'($urandom));
        run_op(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        for (int i = 0; i < 6; i++)
            run_op(N'($urandom), N'($urandom), N'($urandom), N'($urandom));

        // Back-to-back with a and b churning every cycle.
        @(negedge clk);
        start = 1'b1; x = N'($urandom); y = N'($urandom);
        for (int i = 0; i < 45; i++) begin
            a = N'($urandom); b = N'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (22) @(negedge clk);

        // Reset sampled at edge 8, mid-MULX.
        @(negedge clk);
        start = 1'b1; a = N'($urandom); b = N'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(N'($urandom), N'($urandom), N'($urandom), N'($urandom));

        check("queue_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
